// File: rtl/vga_pkg.sv
// Shared timing constants and pixel/coordinate types for the VGA scan path.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  function automatic logic in_span(
    input coord_t v,
    input int     lo,
    input int     hi
  );
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register; DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_taps
    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++)
          taps[i] <= RST_VAL;
      end else if (en) begin
        taps[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          taps[i] <= taps[i-1];
      end
    end

    assign q = taps[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_timing.sv
// VGA scan counters, sync decode, latency alignment and registered pin stage.
module vga_scan_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int PIX_LAT  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] pix_rgb,
  output logic        pix_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        blank_n
);

  import vga_pkg::*;

  localparam int LINE_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRM_LEN  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic   x_wrap;
  logic   y_wrap;
  logic   hs_raw;
  logic   vs_raw;
  logic   vis_raw;
  logic   dly_hs;
  logic   dly_vs;
  logic   dly_vis;
  rgb24_t rgb;
  logic   rgb_unused;

  assign x_wrap = DrawX == coord_t'(LINE_LEN - 1);
  assign y_wrap = DrawY == coord_t'(FRM_LEN - 1);

  always_comb begin
    hs_raw  = !in_span(DrawX, HS_START, HS_END);
    vs_raw  = !in_span(DrawY, VS_START, VS_END);
    vis_raw = (int'(DrawX) < H_ACTIVE) && (int'(DrawY) < V_ACTIVE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en      <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (pix_en) begin
        DrawX <= x_wrap ? '0 : DrawX + 10'd1;
        if (x_wrap)
          DrawY <= y_wrap ? '0 : DrawY + 10'd1;
        if (x_wrap && y_wrap) begin
          frame_start <= 1'b1;
          frame_cnt   <= frame_cnt + 16'd1;
        end
      end
    end
  end

  // Taps reset to the idle pin state so nothing glitches after reset.
  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT),
    .RST_VAL (3'b110)
  ) u_dly (
    .clk (Clk),
    .rst (Reset),
    .en  (pix_en),
    .d   ({hs_raw, vs_raw, vis_raw}),
    .q   ({dly_hs, dly_vs, dly_vis})
  );

  assign rgb        = rgb24_t'(pix_rgb);
  assign rgb_unused = ^{rgb.r[3:0], rgb.g[3:0], rgb.b[3:0]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      VGA_HS  <= 1'b1;
      VGA_VS  <= 1'b1;
      blank_n <= 1'b0;
      VGA_R   <= '0;
      VGA_G   <= '0;
      VGA_B   <= '0;
    end else if (pix_en) begin
      VGA_HS  <= dly_hs;
      VGA_VS  <= dly_vs;
      blank_n <= dly_vis;
      VGA_R   <= dly_vis ? rgb.r[7:4] : 4'h0;
      VGA_G   <= dly_vis ? rgb.g[7:4] : 4'h0;
      VGA_B   <= dly_vis ? rgb.b[7:4] : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing; short frame (10 lines) keeps runtime small.
module tb_vga_scan_timing;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [23:0] pix_rgb = 24'hFF8011;
  logic        pix_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic        blank_n;

  int checks = 0;
  int errors = 0;
  int n;
  int vs_low;
  int fs;

  vga_scan_timing #(
    .V_ACTIVE (4),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .PIX_LAT  (2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_rgb     (pix_rgb),
    .pix_en      (pix_en),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .blank_n     (blank_n)
  );

  always #5 Clk = ~Clk;

  `define CHK(tag, obs, exp) \
    begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
        errors++; \
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
      end \
    end

  task automatic next_tick();
    logic was;
    for (int i = 0; i < 2; i++) begin
      was = pix_en;
      @(posedge Clk);
      #1;
      if (was) break;
    end
  endtask

  task automatic wait_xy(input int x, input int y, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (DrawX == 10'(x) && DrawY == 10'(y)) break;
      next_tick();
    end
    checks++;
    if (DrawX !== 10'(x) || DrawY !== 10'(y)) begin
      errors++;
      $error("FAIL wait_xy expired: at %0d,%0d want %0d,%0d",
             DrawX, DrawY, x, y);
    end
  endtask

  task automatic chk_rst(input string tag);
    checks++;
    if (pix_en !== 1'b0 || DrawX !== 10'd0 || DrawY !== 10'd0 ||
        frame_start !== 1'b0 || frame_cnt !== 16'd0 ||
        VGA_HS !== 1'b1 || VGA_VS !== 1'b1 || blank_n !== 1'b0 ||
        VGA_R !== 4'h0 || VGA_G !== 4'h0 || VGA_B !== 4'h0) begin
      errors++;
      $error("FAIL %s: outputs not at reset values", tag);
    end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk_rst("rst_state");
    `CHK("rst_pix_en", pix_en, 1'b0)
    `CHK("rst_x", DrawX, 10'd0)
    `CHK("rst_y", DrawY, 10'd0)
    `CHK("rst_hs", VGA_HS, 1'b1)
    `CHK("rst_vs", VGA_VS, 1'b1)
    `CHK("rst_blank", blank_n, 1'b0)
    `CHK("rst_r", VGA_R, 4'h0)
    `CHK("rst_fcnt", frame_cnt, 16'd0)
    `CHK("rst_fs", frame_start, 1'b0)
    Reset = 1'b0;

    @(posedge Clk);
    #1;
    `CHK("pix_en_1", pix_en, 1'b1)
    `CHK("x_after_1", DrawX, 10'd0)
    @(posedge Clk);
    #1;
    `CHK("pix_en_2", pix_en, 1'b0)
    `CHK("x_after_2", DrawX, 10'd1)
    `CHK("hs_idle", VGA_HS, 1'b1)
    `CHK("rgb_idle", VGA_R, 4'h0)
    `CHK("fs_no_release", frame_start, 1'b0)

    wait_xy(799, 0, 1000);
    `CHK("reach_799", DrawX, 10'd799)
    next_tick();
    `CHK("x_wrap", DrawX, 10'd0)
    `CHK("y_step", DrawY, 10'd1)

    wait_xy(100, 1, 200);
    `CHK("vis_blank", blank_n, 1'b1)
    `CHK("vis_r", VGA_R, 4'hF)
    `CHK("vis_g", VGA_G, 4'h8)
    `CHK("vis_b", VGA_B, 4'h1)

    pix_rgb = 24'h000000;
    @(posedge Clk);
    #1;
    pix_rgb = 24'hFF8011;
    `CHK("rgb_between", VGA_R, 4'hF)
    next_tick();
    `CHK("rgb_after", VGA_G, 4'h8)

    wait_xy(640, 1, 1000);
    n = 0;
    while (blank_n && n < 10) begin
      next_tick();
      n++;
    end
    `CHK("blank_lat", n, 3)
    `CHK("blank_r", VGA_R, 4'h0)
    `CHK("blank_g", VGA_G, 4'h0)
    `CHK("blank_b", VGA_B, 4'h0)

    wait_xy(656, 1, 100);
    n = 0;
    while (VGA_HS && n < 10) begin
      next_tick();
      n++;
    end
    `CHK("hs_lat", n, 3)
    n = 0;
    while (!VGA_HS && n < 200) begin
      next_tick();
      n++;
    end
    `CHK("hs_width", n, 96)

    vs_low = 0;
    fs = 0;
    for (int i = 0; i < 9000; i++) begin
      if (DrawX == 10'd799 && DrawY == 10'd9) break;
      next_tick();
      if (!VGA_VS) vs_low++;
      if (frame_start) fs++;
    end
    `CHK("end_x", DrawX, 10'd799)
    `CHK("end_y", DrawY, 10'd9)
    `CHK("vs_width", vs_low, 1600)
    `CHK("fs_early", fs, 0)
    `CHK("fcnt_pre", frame_cnt, 16'd0)
    next_tick();
    `CHK("frame_x0", DrawX, 10'd0)
    `CHK("frame_y0", DrawY, 10'd0)
    `CHK("fs_pulse", frame_start, 1'b1)
    `CHK("fcnt_1", frame_cnt, 16'd1)
    @(posedge Clk);
    #1;
    `CHK("fs_one_clk", frame_start, 1'b0)

    wait_xy(300, 3, 4000);
    `CHK("mid_x", DrawX, 10'd300)
    `CHK("mid_vis", blank_n, 1'b1)
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk_rst("mid_rst_state");
    `CHK("mid_rst_x", DrawX, 10'd0)
    `CHK("mid_rst_y", DrawY, 10'd0)
    `CHK("mid_rst_pix_en", pix_en, 1'b0)
    `CHK("mid_rst_fcnt", frame_cnt, 16'd0)
    `CHK("mid_rst_fs", frame_start, 1'b0)
    `CHK("mid_rst_hs", VGA_HS, 1'b1)
    `CHK("mid_rst_vs", VGA_VS, 1'b1)
    `CHK("mid_rst_blank", blank_n, 1'b0)
    `CHK("mid_rst_r", VGA_R, 4'h0)
    Reset = 1'b0;

    force dut.frame_cnt = 16'hFFFF;
    @(posedge Clk);
    #1;
    release dut.frame_cnt;
    `CHK("fcnt_preload", frame_cnt, 16'hFFFF)
    for (int i = 0; i < 9000; i++) begin
      next_tick();
      if (frame_start) break;
    end
    `CHK("wrap_fs", frame_start, 1'b1)
    `CHK("wrap_fcnt", frame_cnt, 16'd0)
    `CHK("wrap_x", DrawX, 10'd0)

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
